// File: rtl/fifo_fill_ctrl.sv
// fifo_fill_ctrl: read-side fill controller for the video read FIFO. It
// watches FIFO free space and issues fixed-length burst reads, plus one short
// tail read at the end of each frame, to the AXI read master. It tracks the
// beats left in the frame and recovers from a hung transaction with a timeout
// and a chain reset.
//
// Ports:
//   clock, rst            rising-edge clock, asynchronous active-high reset
//   enable                allows new requests to leave IDLE
//   frame_start/frame_len one-cycle frame start, beats in the new frame
//   count, fifo_full      write-side fill level and full flag of the FIFO
//   burst_req/tail_req    level requests, req_len = length of current request
//   resp, done            request accepted / last beat written (pulses)
//   burst_done/tail_done/frame_done   one-cycle completion pulses
//   remain                beats still to fetch in this frame
//   rst_chain             one-cycle pulse when a transaction times out
module fifo_fill_ctrl #(
  parameter int          DEPTH     = 512,
  parameter int          BURST_LEN = 128,
  parameter int          LSIZE     = 9,
  parameter int          CSIZE     = 10,
  parameter int          FSIZE     = 24,
  parameter logic [23:0] TIMEOUT   = 24'hFFF000
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic             frame_start,
  input  logic [FSIZE-1:0] frame_len,
  input  logic [CSIZE-1:0] count,
  input  logic             fifo_full,
  output logic             burst_req,
  output logic             tail_req,
  output logic [LSIZE-1:0] req_len,
  input  logic             resp,
  input  logic             done,
  output logic             burst_done,
  output logic             tail_done,
  output logic             frame_done,
  output logic [FSIZE-1:0] remain,
  output logic             rst_chain
);

  typedef enum logic [3:0] {
    IDLE,
    REQ_BURST,
    WAIT_BURST,
    BURST_FSH,
    REQ_TAIL,
    WAIT_TAIL,
    TAIL_FSH,
    TIME_ERR,
    RESET_CHAIN
  } state_t;

  localparam logic [CSIZE:0]   DEPTH_C = (CSIZE+1)'(DEPTH);
  localparam logic [CSIZE:0]   BURST_C = (CSIZE+1)'(BURST_LEN);
  localparam logic [FSIZE-1:0] BURST_F = FSIZE'(BURST_LEN);
  localparam logic [LSIZE-1:0] BURST_L = LSIZE'(BURST_LEN);

  state_t             state_q, state_d;
  logic [CSIZE:0]     free_q, free_d;
  logic [FSIZE-1:0]   remain_q, remain_d;
  logic [LSIZE-1:0]   req_len_q, req_len_d;
  logic               pending_q, pending_d;
  logic [FSIZE-1:0]   pend_len_q, pend_len_d;
  logic [23:0]        to_q, to_d;
  logic [3:0]         rc_q, rc_d;
  logic               burst_req_q, burst_req_d;
  logic               tail_req_q, tail_req_d;
  logic               burst_done_q, burst_done_d;
  logic               tail_done_q, tail_done_d;
  logic               frame_done_q, frame_done_d;
  logic               rst_chain_q, rst_chain_d;

  logic               tail_ok, burst_ok, to_hit;
  logic               fsh_entry, idle_entry;
  logic [FSIZE+CSIZE:0] free_w, remain_w;
  logic [FSIZE-1:0]   req_ext, dec_val;
  logic [CSIZE:0]     count_w;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Compare free space and remaining beats at a common width.
    free_w   = {{FSIZE{1'b0}}, free_q};
    remain_w = {{(CSIZE+1){1'b0}}, remain_q};
    tail_ok  = (remain_q != '0) && (remain_q < BURST_F) && (free_w >= remain_w);
    burst_ok = (remain_q >= BURST_F) && (free_q >= BURST_C) && !fifo_full;
    // The counter holds TIMEOUT-1 in the last allowed REQ/WAIT cycle.
    to_hit   = (to_q == (TIMEOUT - 24'd1));

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          if (tail_ok)       state_d = REQ_TAIL;
          else if (burst_ok) state_d = REQ_BURST;
        end
      end
      REQ_BURST: begin
        if (to_hit)              state_d = TIME_ERR;
        else if (resp && done)   state_d = BURST_FSH;
        else if (resp)           state_d = WAIT_BURST;
      end
      WAIT_BURST: begin
        if (to_hit)    state_d = TIME_ERR;
        else if (done) state_d = BURST_FSH;
      end
      BURST_FSH: state_d = IDLE;
      REQ_TAIL: begin
        if (to_hit)              state_d = TIME_ERR;
        else if (resp && done)   state_d = TAIL_FSH;
        else if (resp)           state_d = WAIT_TAIL;
      end
      WAIT_TAIL: begin
        if (to_hit)    state_d = TIME_ERR;
        else if (done) state_d = TAIL_FSH;
      end
      TAIL_FSH:    state_d = IDLE;
      TIME_ERR:    state_d = RESET_CHAIN;
      RESET_CHAIN: if (rc_q == 4'd15) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered output decodes
  // ---------------------------------------------------------------------------
  always_comb begin
    count_w = {1'b0, count};
    if (count_w > DEPTH_C) free_d = '0;
    else                   free_d = DEPTH_C - count_w;

    to_d = '0;
    if (state_q == REQ_BURST || state_q == WAIT_BURST ||
        state_q == REQ_TAIL  || state_q == WAIT_TAIL)
      to_d = to_q + 24'd1;

    rc_d = '0;
    if (state_q == RESET_CHAIN) rc_d = rc_q + 4'd1;

    req_len_d = req_len_q;
    if (state_q == IDLE && state_d == REQ_BURST) req_len_d = BURST_L;
    if (state_q == IDLE && state_d == REQ_TAIL)  req_len_d = remain_q[LSIZE-1:0];

    req_ext    = {{(FSIZE-LSIZE){1'b0}}, req_len_q};
    dec_val    = (remain_q >= req_ext) ? (remain_q - req_ext) : '0;
    fsh_entry  = (state_d == BURST_FSH) || (state_d == TAIL_FSH);
    idle_entry = (state_d == IDLE) && (state_q != IDLE);

    remain_d     = remain_q;
    pending_d    = pending_q;
    pend_len_d   = pend_len_q;
    frame_done_d = 1'b0;

    if (state_d == TIME_ERR) begin
      remain_d = '0;
    end else if (fsh_entry && !pending_q) begin
      // A frame restarted mid-request discards this request's decrement.
      remain_d     = dec_val;
      frame_done_d = (dec_val == '0);
    end

    if (idle_entry && (pending_q || frame_start)) begin
      remain_d  = frame_start ? frame_len : pend_len_q;
      pending_d = 1'b0;
    end else if (frame_start && state_q == IDLE) begin
      remain_d = frame_len;
    end else if (frame_start) begin
      pending_d  = 1'b1;
      pend_len_d = frame_len;
    end

    burst_req_d  = (state_d == REQ_BURST);
    tail_req_d   = (state_d == REQ_TAIL);
    burst_done_d = (state_d == BURST_FSH);
    tail_done_d  = (state_d == TAIL_FSH);
    rst_chain_d  = (state_d == TIME_ERR);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      free_q       <= '0;
      remain_q     <= '0;
      req_len_q    <= '0;
      pending_q    <= 1'b0;
      pend_len_q   <= '0;
      to_q         <= '0;
      rc_q         <= '0;
      burst_req_q  <= 1'b0;
      tail_req_q   <= 1'b0;
      burst_done_q <= 1'b0;
      tail_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      rst_chain_q  <= 1'b0;
    end else begin
      free_q       <= free_d;
      remain_q     <= remain_d;
      req_len_q    <= req_len_d;
      pending_q    <= pending_d;
      pend_len_q   <= pend_len_d;
      to_q         <= to_d;
      rc_q         <= rc_d;
      burst_req_q  <= burst_req_d;
      tail_req_q   <= tail_req_d;
      burst_done_q <= burst_done_d;
      tail_done_q  <= tail_done_d;
      frame_done_q <= frame_done_d;
      rst_chain_q  <= rst_chain_d;
    end
  end

  assign burst_req  = burst_req_q;
  assign tail_req   = tail_req_q;
  assign req_len    = req_len_q;
  assign burst_done = burst_done_q;
  assign tail_done  = tail_done_q;
  assign frame_done = frame_done_q;
  assign remain     = remain_q;
  assign rst_chain  = rst_chain_q;

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Testbench for fifo_fill_ctrl: per-cycle vector table plus hand-written
// sequences for a full frame, timeout recovery, mid-request frame restart and
// asynchronous reset.
module tb_fifo_fill_ctrl;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [23:0] frame_len = '0;
  logic [9:0]  count = '0;
  logic        fifo_full = 1'b0;
  logic        resp = 1'b0;
  logic        done = 1'b0;
  logic        burst_req, tail_req, burst_done, tail_done, frame_done, rst_chain;
  logic [8:0]  req_len;
  logic [23:0] remain;

  fifo_fill_ctrl #(
    .DEPTH(512), .BURST_LEN(128), .LSIZE(9), .CSIZE(10), .FSIZE(24),
    .TIMEOUT(24'd100)
  ) dut (
    .clock(clock), .rst(rst), .enable(enable), .frame_start(frame_start),
    .frame_len(frame_len), .count(count), .fifo_full(fifo_full),
    .burst_req(burst_req), .tail_req(tail_req), .req_len(req_len),
    .resp(resp), .done(done), .burst_done(burst_done), .tail_done(tail_done),
    .frame_done(frame_done), .remain(remain), .rst_chain(rst_chain)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en, fs;
    logic [23:0] fl;
    logic [9:0]  cnt;
    logic        full, rsp, dn;
    logic        br, tr;
    logic [8:0]  rl;
    logic        bd, td, fd;
    logic [23:0] rm;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; frame_start = 1'b0; frame_len = '0;
    count = '0; fifo_full = 1'b0; resp = 1'b0; done = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic en, input logic fs, input logic [23:0] fl,
                              input logic [9:0] cnt, input logic full, input logic rsp,
                              input logic dn, input logic br, input logic tr,
                              input logic [8:0] rl, input logic bd, input logic td,
                              input logic fd, input logic [23:0] rm);
    vec_t v;
    v.en = en; v.fs = fs; v.fl = fl; v.cnt = cnt; v.full = full; v.rsp = rsp; v.dn = dn;
    v.br = br; v.tr = tr; v.rl = rl; v.bd = bd; v.td = td; v.fd = fd; v.rm = rm;
    return v;
  endfunction

  function automatic logic [63:0] pack_out();
    return {25'd0, burst_req, tail_req, req_len, burst_done, tail_done,
            frame_done, remain, rst_chain};
  endfunction

  vec_t tbl[$];

  initial begin
    logic [63:0] exp_v;
    int ph, cnt, post, nb, nt, nf, ncoinc;
    int lens[$];
    int kinds[$];
    int cyc, t_rc, t_br, nrc, nfd;
    logic [23:0] rem_at_rc, rem16, rem17;
    logic found;

    //   en fs  fl    cnt  full rsp dn | br tr rl  bd td fd rem
    tbl.push_back(mk(0,1, 200,   0, 0,0,0, 0,0,  0, 0,0,0, 200));
    tbl.push_back(mk(0,0,   0,   0, 0,0,0, 0,0,  0, 0,0,0, 200));
    tbl.push_back(mk(0,0,   0,   0, 0,0,0, 0,0,  0, 0,0,0, 200));
    tbl.push_back(mk(1,0,   0,   0, 0,0,0, 1,0,128, 0,0,0, 200));
    tbl.push_back(mk(1,0,   0,   0, 0,1,0, 0,0,128, 0,0,0, 200));
    tbl.push_back(mk(1,0,   0,   0, 0,0,1, 0,0,128, 1,0,0,  72));
    tbl.push_back(mk(1,0,   0,   0, 0,0,0, 0,0,128, 0,0,0,  72));
    tbl.push_back(mk(1,0,   0,   0, 0,0,0, 0,1, 72, 0,0,0,  72));
    tbl.push_back(mk(1,0,   0,   0, 0,1,1, 0,0, 72, 0,1,1,   0));
    tbl.push_back(mk(1,0,   0,   0, 0,0,0, 0,0, 72, 0,0,0,   0));
    tbl.push_back(mk(1,0,   0,   0, 0,0,0, 0,0, 72, 0,0,0,   0));
    tbl.push_back(mk(1,1,1000, 400, 0,0,0, 0,0, 72, 0,0,0,1000));
    tbl.push_back(mk(1,0,   0, 400, 0,0,0, 0,0, 72, 0,0,0,1000));
    tbl.push_back(mk(1,0,   0, 400, 0,0,0, 0,0, 72, 0,0,0,1000));
    tbl.push_back(mk(1,0,   0, 384, 0,0,0, 0,0, 72, 0,0,0,1000));
    tbl.push_back(mk(1,0,   0, 384, 0,0,0, 1,0,128, 0,0,0,1000));
    tbl.push_back(mk(1,0,   0, 384, 0,0,0, 1,0,128, 0,0,0,1000));
    tbl.push_back(mk(1,0,   0, 384, 0,1,1, 0,0,128, 1,0,0, 872));
    tbl.push_back(mk(1,0,   0, 384, 0,0,0, 0,0,128, 0,0,0, 872));
    tbl.push_back(mk(1,0,   0,   0, 1,0,0, 0,0,128, 0,0,0, 872));
    tbl.push_back(mk(1,0,   0,   0, 0,0,0, 1,0,128, 0,0,0, 872));
    tbl.push_back(mk(1,0,   0,   0, 0,1,0, 0,0,128, 0,0,0, 872));
    tbl.push_back(mk(1,0,   0,   0, 0,0,1, 0,0,128, 1,0,0, 744));
    tbl.push_back(mk(1,0,   0,   0, 0,1,1, 0,0,128, 0,0,0, 744));
    tbl.push_back(mk(0,0,   0,   0, 0,1,1, 0,0,128, 0,0,0, 744));
    tbl.push_back(mk(0,1, 100, 413, 0,0,0, 0,0,128, 0,0,0, 100));
    tbl.push_back(mk(1,0,   0, 413, 0,0,0, 0,0,128, 0,0,0, 100));
    tbl.push_back(mk(1,0,   0, 412, 0,0,0, 0,0,128, 0,0,0, 100));
    tbl.push_back(mk(1,0,   0, 412, 0,0,0, 0,1,100, 0,0,0, 100));
    tbl.push_back(mk(1,0,   0, 412, 0,1,0, 0,0,100, 0,0,0, 100));
    tbl.push_back(mk(1,0,   0, 412, 0,0,1, 0,0,100, 0,1,1,   0));
    tbl.push_back(mk(1,0,   0, 412, 0,0,0, 0,0,100, 0,0,0,   0));

    // Reset state
    step(); step();
    check("reset_outputs", pack_out(), 64'd0);
    rst = 1'b0;

    // Vector table: inputs held across one rising edge, outputs checked after it
    for (int i = 0; i < tbl.size(); i++) begin
      enable = tbl[i].en; frame_start = tbl[i].fs; frame_len = tbl[i].fl;
      count = tbl[i].cnt; fifo_full = tbl[i].full; resp = tbl[i].rsp; done = tbl[i].dn;
      step();
      exp_v = {25'd0, tbl[i].br, tbl[i].tr, tbl[i].rl, tbl[i].bd, tbl[i].td,
               tbl[i].fd, tbl[i].rm, 1'b0};
      check($sformatf("vec%0d", i), pack_out(), exp_v);
    end

    // 300-beat frame, resp 5 cycles after a request, done 20 cycles after resp
    do_reset();
    count = '0; enable = 1'b1; frame_len = 24'd300; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    ph = 0; cnt = 0; post = 0; nb = 0; nt = 0; nf = 0; ncoinc = 0;
    for (int c = 0; c < 2000 && post < 10; c++) begin
      if (burst_done) nb++;
      if (tail_done) nt++;
      if (frame_done) begin
        nf++;
        if (tail_done) ncoinc++;
      end
      if (nf > 0) post++;
      case (ph)
        0: if (burst_req || tail_req) begin
             lens.push_back(int'(req_len));
             kinds.push_back(tail_req ? 1 : 0);
             ph = 1; cnt = 0;
           end
        1: begin
             cnt++;
             if (cnt == 5) begin resp = 1'b1; ph = 2; cnt = 0; end
           end
        2: begin
             resp = 1'b0; cnt++;
             if (cnt == 20) begin done = 1'b1; ph = 3; end
           end
        default: begin done = 1'b0; ph = 0; end
      endcase
      step();
    end
    check("frame_nreq", lens.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("frame_len%0d", i), (i < lens.size()) ? lens[i] : -1,
            (i < 2) ? 128 : 44);
      check($sformatf("frame_kind%0d", i), (i < kinds.size()) ? kinds[i] : -1,
            (i < 2) ? 0 : 1);
    end
    check("frame_bdone_cnt", nb, 2);
    check("frame_tdone_cnt", nt, 1);
    check("frame_fdone_cnt", nf, 1);
    check("frame_fdone_with_tdone", ncoinc, 1);
    check("frame_remain_end", remain, 0);

    // Hung transaction: resp arrives, done never does
    do_reset();
    count = '0; enable = 1'b1; frame_len = 24'd1000; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (burst_req) found = 1'b1;
    end
    check("to_req_rise", found, 1);
    cyc = 0; t_rc = -1; t_br = -1; nrc = 0; nfd = 0;
    rem_at_rc = 24'hFFFFFF; rem16 = 24'hFFFFFF; rem17 = 24'hFFFFFF;
    while (cyc < 400 && (t_rc < 0 || cyc < t_rc + 40)) begin
      resp = (cyc == 2);
      frame_start = (t_rc >= 0 && cyc == t_rc + 5);
      frame_len = 24'd500;
      step();
      cyc++;
      if (rst_chain) begin
        nrc++;
        if (t_rc < 0) begin t_rc = cyc; rem_at_rc = remain; end
      end
      if (frame_done) nfd++;
      if (t_rc >= 0 && cyc == t_rc + 16) rem16 = remain;
      if (t_rc >= 0 && cyc == t_rc + 17) rem17 = remain;
      if (t_rc >= 0 && cyc > t_rc && burst_req && t_br < 0) t_br = cyc;
    end
    resp = 1'b0; frame_start = 1'b0;
    check("to_window", (t_rc >= 100 && t_rc <= 101), 1);
    check("to_rst_chain_cnt", nrc, 1);
    check("to_remain_cleared", rem_at_rc, 0);
    check("to_remain_in_chain", rem16, 0);
    check("to_reload_on_idle", rem17, 500);
    check("to_breq_after_idle", t_br - t_rc, 18);
    check("to_no_frame_done", nfd, 0);

    // Frame restart while a burst is waiting for done
    do_reset();
    count = '0; enable = 1'b1; frame_len = 24'd1000; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (burst_req) found = 1'b1;
    end
    check("pend_req_rise", found, 1);
    resp = 1'b1;
    step();
    resp = 1'b0;
    step();
    frame_len = 24'd256; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("pend_bdone", burst_done, 1);
    check("pend_remain_hold", remain, 1000);
    check("pend_no_fdone", frame_done, 0);
    step();
    check("pend_reload", remain, 256);
    step();
    check("pend_next_breq", burst_req, 1);
    check("pend_next_rlen", req_len, 128);

    // Asynchronous reset while REQ_BURST is active
    rst = 1'b1;
    #1;
    check("arst_breq_drop", burst_req, 0);
    check("arst_remain", remain, 0);
    step();
    rst = 1'b0;
    step();
    check("arst_idle_no_req", {burst_req, tail_req}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_fill_ctrl.md
# fifo_fill_ctrl

Read-side counterpart of the VDMA write-path FIFO status controller. It watches the free space of the video read FIFO, which is filled from the AXI read master and drained by the video output. It issues fixed-length burst read requests, plus one short tail request at the end of each frame, to the AXI read master. It tracks the beats remaining in the frame, raises `frame_done` when the last beat has landed, and recovers from a hung transaction with a timeout and chain reset.

## Interface
- `DEPTH`, 512: FIFO depth in beats.
- `BURST_LEN`, 128: beats per normal burst; 0 < `BURST_LEN` <= `DEPTH`.
- `LSIZE`, 9: width of `req_len`; must hold `BURST_LEN`.
- `CSIZE`, 10: width of `count`; 2^`CSIZE` > `DEPTH`.
- `FSIZE`, 24: width of `frame_len` and `remain`.
- `TIMEOUT`, 24'hFFF000: cycles allowed in any request/wait state.

Ports:
- `clock`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  allows new requests from IDLE; does not abort a transaction in flight.
- `frame_start`  in  1  one-cycle pulse; loads `frame_len` into `remain`.
- `frame_len`  in  FSIZE  beats per frame; sampled on `frame_start`.
- `count`  in  CSIZE  FIFO fill level on the write side.
- `fifo_full`  in  1  FIFO full flag.
- `burst_req`  out  1  burst read request, level.
- `tail_req`  out  1  tail read request, level.
- `req_len`  out  LSIZE  length of the current request.
- `resp`  in  1  read master accepted the request.
- `done`  in  1  one-cycle pulse; last beat of the request has been written to the FIFO.
- `burst_done`, `tail_done`, `frame_done`  out  1  one-cycle completion pulses.
- `remain`  out  FSIZE  beats still to fetch in this frame.
- `rst_chain`  out  1  one-cycle pulse on timeout.

## Operation
- Registered `free` = `DEPTH` − `count`, computed at CSIZE+1 bits and updated every cycle.
- Eligibility in IDLE, with `enable`=1:
  - tail: 0 < `remain` < `BURST_LEN` and `free` >= `remain`. Tail has priority over burst.
  - burst: `remain` >= `BURST_LEN`, `free` >= `BURST_LEN`, and `fifo_full`=0.
- States:
  - IDLE → REQ_TAIL or REQ_BURST when eligible; otherwise stay.
  - REQ_x: `resp` → WAIT_x. `resp`&`done` in the same cycle → x_FSH. Timeout → TIME_ERR.
  - WAIT_x: `done` → x_FSH. Timeout → TIME_ERR.
  - BURST_FSH / TAIL_FSH → IDLE after 1 cycle.
  - TIME_ERR → RESET_CHAIN after 1 cycle.
  - RESET_CHAIN: hold 16 cycles, then IDLE.
- `req_len` loads `BURST_LEN` on entry to REQ_BURST and `remain`[LSIZE-1:0] on entry to REQ_TAIL. It holds otherwise.
- `remain` decrements by `req_len` on entry to x_FSH; it never underflows.
  - If the result is 0, `frame_done` pulses together with `burst_done`/`tail_done`.
- `frame_start`:
  - In IDLE: reload `remain` next cycle.
  - In any other state: set `pending`. The reload happens on the next IDLE entry (takes effect the cycle after entry); the decrement of the finishing request is discarded and `pending` clears.
- Timeout:
  - A counter clears in IDLE and increments in REQ_x/WAIT_x.
  - Reaching `TIMEOUT` forces TIME_ERR.
  - TIME_ERR pulses `rst_chain` and clears `remain` to 0; no `frame_done` is raised.
- `enable`=0 only blocks leaving IDLE.

## Timing
- Reset: all outputs 0. State IDLE; `remain`, `pending`, and the timeout counter are 0.
- Outputs are registered decodes of next state:
  - `burst_req` is 1 exactly while in REQ_BURST; `tail_req` exactly while in REQ_TAIL.
  - A request rises 1 cycle after eligibility is seen in IDLE.
  - A request falls the cycle after `resp`.
- `req_len` is valid from the first cycle the request is high.
- `burst_done`/`tail_done`/`frame_done` pulse 1 cycle after the `done` cycle.
- Minimum spacing between a `done` and the next request rising is 3 cycles: FSH, IDLE re-evaluation with refreshed `free`, then request. `count` must reflect the delivered data by `done`+1.
- `done` outside REQ_x/WAIT_x is ignored. `resp` outside REQ_x is ignored.
- Asynchronous `rst` mid-transaction returns to IDLE immediately; requests drop in the same cycle.

## Test plan
- Frame of 300 beats, `count`=0, `resp`/`done` returned after 5/20 cycles:
  - Expect two bursts with `req_len`=128, then one tail with `req_len`=44.
  - Expect `frame_done` once, coincident with `tail_done`; `remain`=0.
- `count`=400 (free 112), frame of 1000 beats: no `burst_req`. Lower `count` to 384 → `burst_req` rises 2 cycles later.
- `resp` and `done` in the same cycle during REQ_BURST → `burst_done` the next cycle; no WAIT cycle; `remain` decrements by 128.
- `done` withheld with `TIMEOUT` set to 100 in the bench → `rst_chain` pulses once, `remain`=0, IDLE re-entered 17 cycles after TIME_ERR, no `frame_done`.
- `frame_start` with `frame_len`=256 during WAIT_BURST → after that burst's `done`, `remain`=256 (not 128 less) and the next burst issues.
- `enable`=0 with `remain`=200 and FIFO empty → no request. Raise `enable` → `burst_req` the next cycle. Assert `rst` during REQ_BURST → `burst_req`=0 immediately.
